// File: rtl/cdb_broadcaster.sv
// CDB broadcaster: buffers per-FU completion tags and drives up to SS_SIZE
// wake-up lanes per cycle using a round-robin scan, with backpressure per FU.
module cdb_broadcaster #(
    parameter int NUM_FU    = 5,
    parameter int SS_SIZE   = 3,
    parameter int PREG_W    = 6,
    parameter int BUF_DEPTH = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             flush,
    input  logic [NUM_FU-1:0]                fu_done,
    input  logic [NUM_FU-1:0][PREG_W-1:0]    fu_tag,
    output logic [NUM_FU-1:0]                fu_stall,
    output logic [SS_SIZE-1:0]               CAM_en,
    output logic [SS_SIZE-1:0][PREG_W-1:0]   CDB_out,
    output logic                             overflow_err
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(BUF_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    logic [PREG_W-1:0] mem_q  [NUM_FU][BUF_DEPTH];
    logic [PREG_W-1:0] mem_d  [NUM_FU][BUF_DEPTH];
    logic [PTR_W-1:0]  head_q [NUM_FU];
    logic [PTR_W-1:0]  head_d [NUM_FU];
    logic [PTR_W-1:0]  tail_q [NUM_FU];
    logic [PTR_W-1:0]  tail_d [NUM_FU];
    logic [CNT_W-1:0]  cnt_q  [NUM_FU];
    logic [CNT_W-1:0]  cnt_d  [NUM_FU];
    logic [RR_W-1:0]   rr_q, rr_d;
    logic [SS_SIZE-1:0]             cam_q, cam_d;
    logic [SS_SIZE-1:0][PREG_W-1:0] cdb_q, cdb_d;
    logic                           ovf_q, ovf_d;

    logic [NUM_FU-1:0]              win_s;
    logic [SS_SIZE-1:0]             lane_vld_s;
    logic [SS_SIZE-1:0][PREG_W-1:0] lane_tag_s;
    logic [RR_W-1:0]                nxt_rr_s;

    // Backpressure decoded from registered occupancy only.
    always_comb begin
        fu_stall = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_stall[i] = (cnt_q[i] == CNT_W'(BUF_DEPTH));
        end
    end

    // Round-robin scan from rr_q, first SS_SIZE non-empty FUs take lanes in order.
    always_comb begin
        int n;
        int idx;
        int last;
        n          = 0;
        idx        = 0;
        last       = 0;
        win_s      = '0;
        lane_vld_s = '0;
        lane_tag_s = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_FU) begin
                idx = idx - NUM_FU;
            end else begin
                idx = idx;
            end
            if ((cnt_q[idx] != '0) && (n < SS_SIZE)) begin
                win_s[idx]      = 1'b1;
                lane_vld_s[n]   = 1'b1;
                lane_tag_s[n]   = mem_q[idx][head_q[idx]];
                last            = idx;
                n               = n + 1;
            end else begin
                n = n;
            end
        end
        if (n == 0) begin
            nxt_rr_s = rr_q;
        end else if (last == NUM_FU - 1) begin
            nxt_rr_s = '0;
        end else begin
            nxt_rr_s = RR_W'(last + 1);
        end
    end

    // Next state: flush squashes everything; otherwise pop winners, push accepted tags.
    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        rr_d   = rr_q;
        cam_d  = '0;
        cdb_d  = '0;
        ovf_d  = ovf_q;
        if (flush) begin
            rr_d = '0;
            for (int i = 0; i < NUM_FU; i++) begin
                head_d[i] = '0;
                tail_d[i] = '0;
                cnt_d[i]  = '0;
            end
        end else begin
            rr_d  = nxt_rr_s;
            cam_d = lane_vld_s;
            cdb_d = lane_tag_s;
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_done[i] && !fu_stall[i]) begin
                    mem_d[i][tail_q[i]] = fu_tag[i];
                    tail_d[i]           = ptr_inc(tail_q[i]);
                end else begin
                    tail_d[i] = tail_q[i];
                end
                if (win_s[i]) begin
                    head_d[i] = ptr_inc(head_q[i]);
                end else begin
                    head_d[i] = head_q[i];
                end
                case ({fu_done[i] && !fu_stall[i], win_s[i]})
                    2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    default: cnt_d[i] = cnt_q[i];
                endcase
                if (fu_done[i] && fu_stall[i]) begin
                    ovf_d = 1'b1;
                end else begin
                    ovf_d = ovf_d;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q  <= '{default: '0};
            head_q <= '{default: '0};
            tail_q <= '{default: '0};
            cnt_q  <= '{default: '0};
            rr_q   <= '0;
            cam_q  <= '0;
            cdb_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            rr_q   <= rr_d;
            cam_q  <= cam_d;
            cdb_q  <= cdb_d;
            ovf_q  <= ovf_d;
        end
    end

    assign CAM_en       = cam_q;
    assign CDB_out      = cdb_q;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Bench for cdb_broadcaster: directed vector table, corner-case sequences and
// random traffic checked against a queue-based reference model.
module tb_cdb_broadcaster;
    localparam int N = 5;
    localparam int S = 3;
    localparam int W = 6;
    localparam int D = 2;

    logic               clock;
    logic               reset;
    logic               flush;
    logic [N-1:0]       fu_done;
    logic [N-1:0][W-1:0] fu_tag;
    logic [N-1:0]       fu_stall;
    logic [S-1:0]       CAM_en;
    logic [S-1:0][W-1:0] CDB_out;
    logic               overflow_err;

    cdb_broadcaster #(.NUM_FU(N), .SS_SIZE(S), .PREG_W(W), .BUF_DEPTH(D)) dut (
        .clock(clock), .reset(reset), .flush(flush), .fu_done(fu_done),
        .fu_tag(fu_tag), .fu_stall(fu_stall), .CAM_en(CAM_en),
        .CDB_out(CDB_out), .overflow_err(overflow_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [W-1:0]        mq [N][$];
    int                  m_rr;
    logic                m_ovf;
    logic [S-1:0]        e_cam;
    logic [S-1:0][W-1:0] e_cdb;
    logic [W-1:0]        obs [$];

    typedef struct {
        logic [N-1:0]        done;
        logic [N-1:0][W-1:0] tag;
        logic                fl;
        logic [S-1:0]        cam;
        logic [S-1:0][W-1:0] cdb;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(logic [4:0] d, logic [29:0] t, logic f, logic [2:0] c, logic [17:0] b);
        vec_t v;
        v.done = d; v.tag = t; v.fl = f; v.cam = c; v.cdb = b;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_rr = 0; m_ovf = 1'b0; e_cam = '0; e_cdb = '0;
    endtask

    task automatic model_edge(input logic [N-1:0] d, input logic [N-1:0][W-1:0] t, input logic f);
        logic [N-1:0] st;
        int n, last, idx;
        e_cam = '0; e_cdb = '0;
        if (f) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_rr = 0;
        end else begin
            for (int i = 0; i < N; i++) st[i] = (mq[i].size() == D);
            n = 0; last = 0;
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (mq[idx].size() > 0 && n < S) begin
                    e_cdb[n] = mq[idx].pop_front();
                    e_cam[n] = 1'b1;
                    last = idx;
                    n++;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (d[i] && !st[i]) mq[i].push_back(t[i]);
                if (d[i] && st[i]) m_ovf = 1'b1;
            end
            if (n > 0) m_rr = (last + 1) % N;
        end
    endtask

    task automatic step(input logic [N-1:0] d, input logic [N-1:0][W-1:0] t, input logic f);
        logic [N-1:0] es;
        fu_done = d; fu_tag = t; flush = f;
        @(posedge clock);
        model_edge(d, t, f);
        #1;
        for (int i = 0; i < N; i++) es[i] = (mq[i].size() == D);
        check("cam_en", 32'(CAM_en), 32'(e_cam));
        check("cdb_out", 32'(CDB_out), 32'(e_cdb));
        check("fu_stall", 32'(fu_stall), 32'(es));
        check("overflow_err", 32'(overflow_err), 32'(m_ovf));
        for (int l = 0; l < S; l++) if (CAM_en[l]) obs.push_back(CDB_out[l]);
    endtask

    initial begin
        logic [N-1:0]        d;
        logic [N-1:0][W-1:0] t;
        int                  fu2_next;
        bit                  ok, saw;

        reset = 1'b0; flush = 1'b0; fu_done = '0; fu_tag = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("rst_cam", 32'(CAM_en), 32'd0);
        check("rst_cdb", 32'(CDB_out), 32'd0);
        check("rst_stall", 32'(fu_stall), 32'd0);
        check("rst_ovf", 32'(overflow_err), 32'd0);
        reset = 1'b1;

        // Directed vectors from a fresh reset (rr_ptr = 0)
        tbl[0]  = mk(5'b11111, {6'd14, 6'd13, 6'd12, 6'd11, 6'd10}, 1'b0, 3'b000, 18'd0);
        tbl[1]  = mk(5'b00000, 30'd0, 1'b0, 3'b111, {6'd12, 6'd11, 6'd10});
        tbl[2]  = mk(5'b00000, 30'd0, 1'b0, 3'b011, {6'd0, 6'd14, 6'd13});
        tbl[3]  = mk(5'b00000, 30'd0, 1'b0, 3'b000, 18'd0);
        tbl[4]  = mk(5'b00001, {24'd0, 6'd17}, 1'b0, 3'b000, 18'd0);
        tbl[5]  = mk(5'b00000, 30'd0, 1'b0, 3'b001, {12'd0, 6'd17});
        tbl[6]  = mk(5'b00000, 30'd0, 1'b0, 3'b000, 18'd0);
        tbl[7]  = mk(5'b11111, {6'd24, 6'd23, 6'd22, 6'd21, 6'd20}, 1'b0, 3'b000, 18'd0);
        tbl[8]  = mk(5'b00010, {18'd0, 6'd22, 6'd0}, 1'b1, 3'b000, 18'd0);
        tbl[9]  = mk(5'b00000, 30'd0, 1'b0, 3'b000, 18'd0);
        tbl[10] = mk(5'b00011, {18'd0, 6'd6, 6'd5}, 1'b0, 3'b000, 18'd0);
        tbl[11] = mk(5'b00000, 30'd0, 1'b0, 3'b011, {6'd0, 6'd6, 6'd5});
        for (int v = 0; v < 12; v++) begin
            step(tbl[v].done, tbl[v].tag, tbl[v].fl);
            check($sformatf("tbl%0d_cam", v), 32'(CAM_en), 32'(tbl[v].cam));
            check($sformatf("tbl%0d_cdb", v), 32'(CDB_out), 32'(tbl[v].cdb));
        end
        repeat (3) step('0, '0, 1'b0);

        // Backpressure: every FU honours its stall; FU2 tags must emerge 1,2,3.. in order
        obs.delete(); fu2_next = 1; saw = 1'b0;
        for (int c = 0; c < 14; c++) begin
            d = ~fu_stall;
            for (int i = 0; i < N; i++) t[i] = W'(40 + i);
            t[2] = W'(fu2_next);
            if (fu_stall[2]) saw = 1'b1;
            if (d[2]) fu2_next++;
            step(d, t, 1'b0);
        end
        repeat (6) step('0, '0, 1'b0);
        check("bp_stall_seen", 32'(saw), 32'd1);
        ok = 1'b1; fu2_next--;
        begin
            int k;
            k = 0;
            foreach (obs[j]) if (obs[j] < 6'd40) begin
                k++;
                if (int'(obs[j]) != k) ok = 1'b0;
            end
            check("bp_fu2_count", 32'(k), 32'(fu2_next));
        end
        check("bp_fu2_order", 32'(ok), 32'd1);
        check("bp_no_ovf", 32'(overflow_err), 32'd0);

        // Overflow: force FU3 while stalled with tag 9
        saw = 1'b0;
        for (int c = 0; c < 20 && !saw; c++) begin
            if (fu_stall[3]) saw = 1'b1;
            else begin
                for (int i = 0; i < N; i++) t[i] = W'(30 + i);
                step(~fu_stall, t, 1'b0);
            end
        end
        check("ovf_stall_reached", 32'(saw), 32'd1);
        obs.delete();
        for (int i = 0; i < N; i++) t[i] = W'(30 + i);
        t[3] = 6'd9;
        step(~fu_stall | 5'b01000, t, 1'b0);
        check("ovf_set", 32'(overflow_err), 32'd1);
        step('0, '0, 1'b1);
        check("ovf_after_flush", 32'(overflow_err), 32'd1);
        repeat (5) step('0, '0, 1'b0);
        ok = 1'b1;
        foreach (obs[j]) if (obs[j] == 6'd9) ok = 1'b0;
        check("ovf_tag9_dropped", 32'(ok), 32'd1);

        // Asynchronous reset with three tags buffered
        step(5'b00111, {18'd0, 6'd52, 6'd51, 6'd50}, 1'b0);
        reset = 1'b0;
        #1;
        check("arst_cam", 32'(CAM_en), 32'd0);
        check("arst_cdb", 32'(CDB_out), 32'd0);
        check("arst_stall", 32'(fu_stall), 32'd0);
        check("arst_ovf", 32'(overflow_err), 32'd0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        obs.delete();
        repeat (4) step('0, '0, 1'b0);
        check("arst_no_stale", 32'(obs.size()), 32'd0);

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            d = 5'($urandom) & ~fu_stall;
            if ($urandom_range(0, 29) == 0) d = d | 5'($urandom);
            for (int i = 0; i < N; i++) t[i] = W'($urandom);
            step(d, t, ($urandom_range(0, 24) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cdb_broadcaster.md
Name: cdb_broadcaster

Overview:
- Producer end of the CDB/CAM wake-up interface that the reservation station consumes through CAM_en and CDB_in.
- Collects completion tags from the NUM_FU functional units and buffers them per FU.
- Each cycle, round-robin arbitrates up to SS_SIZE tags onto the SS_SIZE CDB lanes.
- Applies backpressure to FUs whose buffer is full, so no completion is lost when more than SS_SIZE FUs finish together.

Parameters:
NUM_FU, 5, number of functional units / completion sources
SS_SIZE, 3, number of CDB lanes (superscalar width)
PREG_W, 6, physical register tag width
BUF_DEPTH, 2, per-FU completion buffer entries (power of 2, >=1)

Ports:
clock  in  1  single clock, rising-edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous squash of all buffered and pending broadcasts
fu_done  in  NUM_FU  FU i has a completed result this cycle
fu_tag  in  NUM_FU x PREG_W  destination physical tag per FU
fu_stall  out  NUM_FU  FU i must not assert fu_done (buffer i full)
CAM_en  out  SS_SIZE  lane valid, drives the RS CAM_en
CDB_out  out  SS_SIZE x PREG_W  broadcast tag per lane, drives the RS CDB_in
overflow_err  out  1  sticky: fu_done asserted while fu_stall was high

Behaviour:
- Reset (reset=0, async):
  - all buffers empty, counts 0, rr_ptr=0;
  - CAM_en=0, CDB_out=0, overflow_err=0, fu_stall=0.
  - A reset mid-operation discards all buffered tags with no partial broadcast.
- Per-FU buffer:
  - circular FIFO of BUF_DEPTH tags with head/tail pointers; pointers wrap modulo BUF_DEPTH.
  - count width is clog2(BUF_DEPTH)+1.
- Backpressure:
  - fu_stall[i] = (count[i]==BUF_DEPTH), decoded from registered state only.
  - It is conservative: a same-cycle pop does not lower it.
- Enqueue: at a rising edge, if fu_done[i] & ~fu_stall[i] & ~flush, push fu_tag[i] to buffer i.
- Overflow: fu_done[i] & fu_stall[i] drops the tag and sets overflow_err. It stays set until reset (flush does not clear it).
- Arbitration (combinational on registered state):
  - candidates are FUs with count>0;
  - scan from index rr_ptr upward with wrap;
  - the first SS_SIZE candidates win, assigned to lanes 0,1,2.. in scan order;
  - lanes without a winner carry CAM_en=0, CDB_out=0.
- Dequeue and broadcast: at the same edge, each winner's head is popped. Its tag and CAM_en=1 load into the registered output lane.
- Pointer update: rr_ptr <= (index of last winner + 1) mod NUM_FU. With no winners, rr_ptr is unchanged.
- Simultaneous push and pop on the same FU: both occur; count unchanged.
- A tag pushed at edge k is broadcastable no earlier than edge k+1.
- Latency: fu_done high in cycle N gives CAM_en visible in cycle N+2 at the earliest (buffer, then output register).
- Broadcast duration: each output is valid for exactly one cycle. The RS samples it that cycle and there is no acknowledge.
- Flush (synchronous, priority over enqueue/dequeue):
  - next edge empties all buffers, clears CAM_en/CDB_out, sets rr_ptr=0;
  - fu_done in the flush cycle is ignored and not flagged.
- Invariants:
  - at most one lane carries any given FU per cycle;
  - the same tag never appears twice in one cycle unless two FUs supplied it;
  - tags from one FU are broadcast in FIFO order.
- Fairness: any non-empty FU is broadcast within ceil(NUM_FU/SS_SIZE) cycles.

Test Plan:
- Reset then idle: reset low mid-traffic with buffers holding 3 tags -> next cycle CAM_en=000, CDB_out=0, fu_stall=0, overflow_err=0; no stale tag ever appears after reset release.
- Single completion: fu_done=00001, fu_tag[0]=6'd17 at cycle 5 -> CAM_en=001, CDB_out[0]=17 in cycle 7 only; CAM_en=000 in cycle 8.
- Oversubscription/fairness: all 5 FUs done in one cycle with tags 10..14, rr_ptr=0 -> first broadcast lanes {10,11,12}, next cycle lanes {13,14} with CAM_en=011, rr_ptr ends at 0.
- Backpressure: FU2 done every cycle with tags 1,2,3.. while FUs 0,1,3,4 also done continuously -> fu_stall[2] rises when count hits 2; FU honouring the stall sees tags broadcast strictly in order 1,2,3 with none lost; overflow_err stays 0.
- Overflow: force fu_done[3]=1 while fu_stall[3]=1 with tag 9 -> tag 9 never broadcast, overflow_err=1 and remains 1 through a flush.
- Flush: 4 tags buffered plus fu_done[1] with tag 22 in the flush cycle -> next cycle CAM_en=000, all fu_stall=0; tag 22 and buffered tags are never broadcast; a new fu_done after the flush broadcasts 2 cycles later with rr_ptr starting from 0.
